// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS mode sequencer.
// Optional feature macro: DDS_LONG_PRESS_EN (long-press frequency stepping).
package dds_pkg;

    // Output waveform encoding driven onto the DDS waveform mux
    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_t;

    // Button debounce FSM states
    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_PRESS   = 2'd1,
        DB_HELD    = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

    localparam int FREQ_IDX_W = 2;
    localparam int FREQ_TW_W  = 32;

    // Tuning words for 1 kHz, 10 kHz, 100 kHz, 1 MHz at a 50 MHz clock (f * 2^32 / 50e6)
    localparam logic [FREQ_TW_W-1:0] FREQ_TABLE [0:3] = '{
        32'd85899,
        32'd858993,
        32'd8589935,
        32'd85899346
    };

endpackage

// File: rtl/dds_mode_sequencer_btn_debounce.sv
// Button synchronizer, debounce FSM and hold-time classifier.
// With DDS_LONG_PRESS_EN defined a hold counter classifies long presses;
// otherwise every press is reported as short.
module btn_debounce
    import dds_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_evt_o,
    output logic press_long_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Configurations this FSM cannot honour (a one-cycle debounce or a long threshold below it)
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < DEBOUNCE_CYCLES) begin : g_cfg_unsupported
    end

    logic [1:0]       sync_q;
    logic             btn_lvl_s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             long_q, long_d;
    logic             hold_long_s;

    assign btn_lvl_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous raw button; idles released (high)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
        end
    end

`ifdef DDS_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign hold_long_s = (hold_q >= HOLD_W'(LONG_CYCLES));

    // Hold counter: clears on entering press debounce, counts (saturating) while held or releasing
    always_comb begin
        hold_d = hold_q;
        if (state_d == DB_PRESS && state_q != DB_PRESS) begin
            hold_d = '0;
        end else if ((state_q == DB_HELD || state_q == DB_RELEASE) && !hold_long_s) begin
            hold_d = hold_q + HOLD_W'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Hold counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_long_s = 1'b0;
`endif

    // Debounce next-state: a level change is accepted after DEBOUNCE_CYCLES consecutive samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (!btn_lvl_s) begin
                    state_d = DB_PRESS;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (btn_lvl_s) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DB_HELD: begin
                if (btn_lvl_s) begin
                    state_d = DB_RELEASE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            DB_RELEASE: begin
                if (!btn_lvl_s) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                    evt_d   = 1'b1;
                    long_d  = hold_long_s;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Debounce state, sample counter and registered press pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            long_q  <= long_d;
        end
    end

    assign press_evt_o  = evt_q;
    assign press_long_o = long_q;

endmodule

// File: rtl/dds_mode_sequencer.sv
// DDS mode sequencer: turns debounced button presses into waveform / frequency
// steps and offers each new configuration over a valid/ready handshake with a
// one-deep pending buffer. Optional macro DDS_LONG_PRESS_EN enables long-press
// frequency stepping; without it the tuning word stays at the first preset.
module dds_mode_sequencer
    import dds_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 65536,
    parameter int TW_W            = 32,
    parameter int NUM_FREQ        = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            iExtBtn,
    output logic [1:0]      oWaveSel,
    output logic [TW_W-1:0] oTuneWord,
    output logic            oCfgValid,
    input  logic            iCfgReady,
    output logic            oPhaseClr
);

    // Preset count must fit the index width
    if (NUM_FREQ < 1 || NUM_FREQ > (1 << FREQ_IDX_W)) begin : g_num_freq_unsupported
    end

    logic                  press_evt_s, press_long_s;
    logic                  xfer_s, apply_s, apply_long_s;
    wave_t                 wave_q, wave_d, last_wave_q, last_wave_d;
    logic [FREQ_IDX_W-1:0] freq_q, freq_d;
    logic [TW_W-1:0]       tune_q, tune_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d, pend_long_q, pend_long_d;
    logic                  clr_q, clr_d;
    logic                  boot_q;

    // Next frequency preset, wrapping after the last one
    function automatic logic [FREQ_IDX_W-1:0] freq_step(input logic [FREQ_IDX_W-1:0] idx);
        if (idx >= FREQ_IDX_W'(NUM_FREQ - 1)) begin
            freq_step = '0;
        end else begin
            freq_step = idx + FREQ_IDX_W'(1);
        end
    endfunction

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_btn_debounce (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .btn_n_i      (iExtBtn),
        .press_evt_o  (press_evt_s),
        .press_long_o (press_long_s)
    );

    assign xfer_s = valid_q && iCfgReady;

    // Handshake / pending-buffer decisions and the resulting configuration update
    always_comb begin
        valid_d      = valid_q;
        pend_d       = pend_q;
        pend_long_d  = pend_long_q;
        last_wave_d  = last_wave_q;
        clr_d        = 1'b0;
        apply_s      = 1'b0;
        apply_long_s = 1'b0;
        wave_d       = wave_q;
        freq_d       = freq_q;
        if (xfer_s) begin
            last_wave_d = wave_q;
            clr_d       = (wave_q != last_wave_q);
            if (pend_q) begin
                // Buffered event goes out next; a coincident new event refills the buffer
                apply_s      = 1'b1;
                apply_long_s = pend_long_q;
                valid_d      = 1'b1;
                pend_d       = press_evt_s;
                pend_long_d  = press_long_s;
            end else if (press_evt_s) begin
                apply_s      = 1'b1;
                apply_long_s = press_long_s;
                valid_d      = 1'b1;
            end else begin
                valid_d      = 1'b0;
            end
        end else if (valid_q) begin
            // Offer outstanding: park one event, drop anything beyond that
            if (press_evt_s && !pend_q) begin
                pend_d      = 1'b1;
                pend_long_d = press_long_s;
            end else begin
                pend_d      = pend_q;
            end
        end else begin
            if (press_evt_s) begin
                apply_s      = 1'b1;
                apply_long_s = press_long_s;
                valid_d      = 1'b1;
            end else if (boot_q) begin
                valid_d      = 1'b1;
            end else begin
                valid_d      = 1'b0;
            end
        end
        if (apply_s) begin
            if (apply_long_s) begin
                freq_d = freq_step(freq_q);
            end else begin
                wave_d = wave_t'(wave_q + 2'd1);
            end
        end else begin
            wave_d = wave_q;
        end
        tune_d = TW_W'(FREQ_TABLE[freq_d]);
    end

    // Configuration, handshake and phase-clear registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wave_q      <= WAVE_SINE;
            last_wave_q <= WAVE_SINE;
            freq_q      <= '0;
            tune_q      <= TW_W'(FREQ_TABLE[0]);
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_long_q <= 1'b0;
            clr_q       <= 1'b0;
            boot_q      <= 1'b1;
        end else begin
            wave_q      <= wave_d;
            last_wave_q <= last_wave_d;
            freq_q      <= freq_d;
            tune_q      <= tune_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
            pend_long_q <= pend_long_d;
            clr_q       <= clr_d;
            boot_q      <= 1'b0;
        end
    end

    assign oWaveSel  = wave_q;
    assign oTuneWord = tune_q;
    assign oCfgValid = valid_q;
    assign oPhaseClr = clr_q;

endmodule

// File: tb/tb_dds_mode_sequencer.sv
// Directed self-checking bench for dds_mode_sequencer (DEBOUNCE_CYCLES=16,
// LONG_CYCLES shortened to 64 so a long press fits a short run).
module tb_dds_mode_sequencer;

    localparam int DB  = 16;
    localparam int LNG = 64;
    localparam logic [31:0] TW0 = 32'd85899;
    localparam logic [31:0] TW1 = 32'd858993;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b1;
    logic        ready = 1'b1;
    logic [1:0]  wave_sel;
    logic [31:0] tune_word;
    logic        cfg_valid;
    logic        phase_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;
    logic [1:0] xfer_log [$];

    dds_mode_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LNG),
        .TW_W            (32),
        .NUM_FREQ        (4)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .iExtBtn   (btn),
        .oWaveSel  (wave_sel),
        .oTuneWord (tune_word),
        .oCfgValid (cfg_valid),
        .iCfgReady (ready),
        .oPhaseClr (phase_clr)
    );

    always #5 clk = ~clk;

    // Record transfers and phase-clear cycles midway between active edges
    always @(negedge clk) begin
        if (cfg_valid && ready) xfer_log.push_back(wave_sel);
        if (phase_clr) clr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int len);
        btn = 1'b0;
        tick(len);
        btn = 1'b1;
        tick(2 * DB + 8);
    endtask

    initial begin
        int lat;
        int clr0;
        logic [1:0] w0;
        tick(3);
        // 1: reset state and single post-reset offer
        check_eq("rst_valid", cfg_valid, 0);
        check_eq("rst_wave", wave_sel, 0);
        check_eq("rst_tune", tune_word, TW0);
        check_eq("rst_clr", phase_clr, 0);
        xfer_log.delete();
        clr0 = clr_cnt;
        rst = 1'b0;
        tick(1);
        check_eq("boot_valid", cfg_valid, 1);
        check_eq("boot_wave", wave_sel, 0);
        check_eq("boot_tune", tune_word, TW0);
        tick(1);
        check_eq("boot_valid_drop", cfg_valid, 0);
        tick(3);
        check_eq("boot_xfers", xfer_log.size(), 1);
        check_eq("boot_no_clr", clr_cnt - clr0, 0);

        // 2: short press latency and phase clear
        clr0 = clr_cnt;
        btn = 1'b0;
        tick(25);
        btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (wave_sel == 2'd1 && lat == 0) lat = i;
        end
        check_eq("press_latency", lat, 19);
        check_eq("press_wave", wave_sel, 1);
        check_eq("press_clr_pulse", clr_cnt - clr0, 1);

        // 3: glitch rejection, then reset while held
        xfer_log.delete();
        press(6);
        check_eq("glitch_xfers", xfer_log.size(), 0);
        check_eq("glitch_wave", wave_sel, 1);
        btn = 1'b0;
        tick(30);
        rst = 1'b1;
        tick(2);
        btn = 1'b1;
        tick(1);
        xfer_log.delete();
        rst = 1'b0;
        tick(1);
        check_eq("rst_held_valid", cfg_valid, 1);
        check_eq("rst_held_wave", wave_sel, 0);
        tick(2 * DB + 8);
        check_eq("rst_held_xfers", xfer_log.size(), 1);
        check_eq("rst_held_wave_after", wave_sel, 0);

        // 4: four short presses cycle the waveform, frequency untouched
        for (int k = 1; k <= 4; k++) begin
            press(25);
            check_eq("cycle_wave", wave_sel, k % 4);
            check_eq("cycle_tune", tune_word, TW0);
        end

        // 5: back-pressure, one pending, one dropped
        ready = 1'b0;
        press(25);
        check_eq("bp_valid", cfg_valid, 1);
        check_eq("bp_wave1", wave_sel, 1);
        press(25);
        check_eq("bp_wave2_held", wave_sel, 1);
        press(25);
        check_eq("bp_wave3_held", wave_sel, 1);
        xfer_log.delete();
        ready = 1'b1;
        tick(5);
        check_eq("bp_xfers", xfer_log.size(), 2);
        if (xfer_log.size() == 2) begin
            check_eq("bp_xfer0", xfer_log[0], 1);
            check_eq("bp_xfer1", xfer_log[1], 2);
        end else begin
            check_eq("bp_xfer_list", xfer_log.size(), 2);
        end
        check_eq("bp_final_wave", wave_sel, 2);
        check_eq("bp_valid_drop", cfg_valid, 0);

        // 6: long press
        w0   = wave_sel;
        clr0 = clr_cnt;
        press(2 * LNG);
`ifdef DDS_LONG_PRESS_EN
        check_eq("long_tune", tune_word, TW1);
        check_eq("long_wave", wave_sel, w0);
        check_eq("long_no_clr", clr_cnt - clr0, 0);
`else
        check_eq("long_tune", tune_word, TW0);
        check_eq("long_wave", wave_sel, 2'(w0 + 2'd1));
        check_eq("long_clr", clr_cnt - clr0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
